w0rm_gpio_in_conditioner: RTL and testbench

//  Input conditioning stage between the board switch pins and the W0RM_Demo gpio_a/gpio_c inputs.

---
 rtl/w0rm_gpio_pkg.sv | 16 +
 rtl/w0rm_debounce_bit.sv | 67 ++++++
 rtl/w0rm_gpio_in_conditioner.sv | 98 +++++++++
 tb/tb_w0rm_gpio_in_conditioner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/w0rm_gpio_pkg.sv
// Shared constants and the change-event record layout used by the W0RM GPIO input path
// and the CPU-side GPIO peripheral.
package w0rm_gpio_pkg;

    localparam int GPIO_WIDTH          = 8;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 1000;

    // Field order is fixed: the GPIO peripheral unpacks this record as {ovf, level, mask}.
    typedef struct packed {
        logic                  ovf;
        logic [GPIO_WIDTH-1:0] level;
        logic [GPIO_WIDTH-1:0] mask;
    } gpio_evt_t;

endpackage

// File: rtl/w0rm_debounce_bit.sv
// One input bit: synchroniser chain, stability counter and registered rise/fall pulses.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module w0rm_debounce_bit
    import w0rm_gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_bit;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   level_reg, level_next;
    logic                   rise_reg, rise_next;
    logic                   fall_reg, fall_next;

    assign sync_bit = sync_reg[SYNC_STAGES-1];

    always_comb begin
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (sync_bit == level_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            // Pulses are registered alongside the level so they appear in the same cycle.
            level_next = sync_bit;
            cnt_next   = '0;
            rise_next  = sync_bit;
            fall_next  = ~sync_bit;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], pin};
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/w0rm_gpio_in_conditioner.sv
// Switch-pin conditioner: per-bit debounce plus a coalescing change-event register
// handed to the GPIO peripheral over valid/ready.
module w0rm_gpio_in_conditioner
    import w0rm_gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_mask,
    output logic [WIDTH-1:0] evt_level,
    output logic             evt_ovf,
    input  logic             ovf_clr
);

    // Same field order as gpio_evt_t, sized by this instance's WIDTH.
    typedef struct packed {
        logic             ovf;
        logic [WIDTH-1:0] level;
        logic [WIDTH-1:0] mask;
    } evt_t;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            w0rm_debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .pin     (pin_in[gi]),
                .level   (data_out[gi]),
                .rise    (rise_out[gi]),
                .fall    (fall_out[gi])
            );
        end
    endgenerate

    evt_t             evt_reg, evt_next;
    logic             evt_valid_reg, evt_valid_next;
    logic [WIDTH-1:0] chg;

    always_comb begin
        chg            = rise_out | fall_out;
        evt_next       = evt_reg;
        evt_valid_next = evt_valid_reg;
        evt_next.ovf   = evt_reg.ovf & ~ovf_clr;
        if (!evt_valid_reg) begin
            if (|chg) begin
                evt_valid_next = 1'b1;
                evt_next.mask  = chg;
                evt_next.level = data_out;
            end
        end else if (evt_ready) begin
            // Old mask was just consumed, so a same-cycle change starts a fresh record.
            if (|chg) begin
                evt_next.mask  = chg;
                evt_next.level = data_out;
            end else begin
                evt_valid_next = 1'b0;
                evt_next.mask  = '0;
            end
        end else begin
            evt_next.mask = evt_reg.mask | chg;
            if (|chg) begin
                evt_next.level = data_out;
            end
            if (|(evt_reg.mask & chg)) begin
                evt_next.ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_reg       <= '0;
            evt_valid_reg <= 1'b0;
        end else begin
            evt_reg       <= evt_next;
            evt_valid_reg <= evt_valid_next;
        end
    end

    assign evt_valid = evt_valid_reg;
    assign evt_mask  = evt_reg.mask;
    assign evt_level = evt_reg.level;
    assign evt_ovf   = evt_reg.ovf;

endmodule

// File: tb/tb_w0rm_gpio_in_conditioner.sv
// Bench for w0rm_gpio_in_conditioner: directed scenarios then random pins/handshake,
// all outputs checked every cycle against a window-based behavioural model.
module tb_w0rm_gpio_in_conditioner;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] pin_in;
    logic [W-1:0] data_out, rise_out, fall_out, evt_mask, evt_level;
    logic         evt_valid, evt_ready, evt_ovf, ovf_clr;

    int n_vec  = 0;
    int n_miss = 0;

    // Model state
    logic [W-1:0] m_data, m_rise, m_fall, m_mask, m_level;
    logic         m_valid, m_ovf;
    logic [W-1:0] syncq[$];
    logic [W-1:0] win[$];

    w0rm_gpio_in_conditioner #(
        .WIDTH           (W),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pin_in    (pin_in),
        .data_out  (data_out),
        .rise_out  (rise_out),
        .fall_out  (fall_out),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_mask  (evt_mask),
        .evt_level (evt_level),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_data = '0; m_rise = '0; m_fall = '0; m_mask = '0; m_level = '0;
        m_valid = 1'b0; m_ovf = 1'b0;
        syncq.delete();
        for (int i = 0; i < SS; i++) syncq.push_back('0);
        win.delete();
    endfunction

    // One rising edge: a level is accepted once the last DC synchronised samples all disagree.
    function automatic void model_step();
        logic [W-1:0] chg, s, acc;
        chg = m_rise | m_fall;
        if (ovf_clr) m_ovf = 1'b0;
        if (!m_valid) begin
            if (chg != 0) begin m_valid = 1'b1; m_mask = chg; m_level = m_data; end
        end else if (evt_ready) begin
            if (chg != 0) begin m_mask = chg; m_level = m_data; end
            else begin m_valid = 1'b0; m_mask = '0; end
        end else begin
            if ((m_mask & chg) != 0) m_ovf = 1'b1;
            m_mask = m_mask | chg;
            if (chg != 0) m_level = m_data;
        end
        s = syncq.pop_front();
        syncq.push_back(pin_in);
        win.push_back(s);
        if (win.size() > DC) void'(win.pop_front());
        acc = '0;
        if (win.size() == DC) begin
            for (int b = 0; b < W; b++) begin
                logic all_diff;
                all_diff = 1'b1;
                for (int k = 0; k < DC; k++) if (win[k][b] == m_data[b]) all_diff = 1'b0;
                acc[b] = all_diff;
            end
        end
        m_rise = acc & ~m_data;
        m_fall = acc & m_data;
        m_data = m_data ^ acc;
    endfunction

    task automatic check_all();
        chk("data_out",  32'(data_out),  32'(m_data));
        chk("rise_out",  32'(rise_out),  32'(m_rise));
        chk("fall_out",  32'(fall_out),  32'(m_fall));
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        chk("evt_mask",  32'(evt_mask),  32'(m_mask));
        chk("evt_level", 32'(evt_level), 32'(m_level));
        chk("evt_ovf",   32'(evt_ovf),   32'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic accept_one();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    initial begin
        int  hold;
        bit  found;

        reset_n = 1'b0; pin_in = 8'h80; evt_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        #11;
        reset_n = 1'b1;
        check_all();

        // 1: pins already high at release give an initial-state event after SS+DC clocks
        ticks(5);
        chk("t1_data_before", 32'(data_out), 32'h00);
        tick();
        chk("t1_data", 32'(data_out), 32'h80);
        chk("t1_rise", 32'(rise_out), 32'h80);
        tick();
        chk("t1_valid", 32'(evt_valid), 32'h1);
        chk("t1_mask",  32'(evt_mask),  32'h80);
        chk("t1_level", 32'(evt_level), 32'h80);
        ticks(3);
        chk("t1_held", 32'(evt_valid), 32'h1);
        accept_one();
        tick();
        chk("t1_done", 32'(evt_valid), 32'h0);

        // 2: glitch shorter than the debounce window
        pin_in = 8'h81;
        ticks(3);
        pin_in = 8'h80;
        ticks(10);
        chk("t2_data0", 32'(data_out[0]), 32'h0);
        chk("t2_noevt", 32'(evt_valid),   32'h0);

        // 3: two changes of bit 1 while the event is unaccepted
        pin_in = 8'h82;
        ticks(10);
        chk("t3_mask", 32'(evt_mask), 32'h02);
        pin_in = 8'h80;
        ticks(8);
        chk("t3_ovf",  32'(evt_ovf),  32'h1);
        chk("t3_mask2", 32'(evt_mask), 32'h02);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 32'(evt_ovf), 32'h0);
        accept_one();

        // 4: accept in the same cycle as a fresh change
        pin_in = 8'h88;
        ticks(8);
        pin_in = 8'h8C;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (m_rise[2]) found = 1'b1;
        end
        chk("t4_rise_seen", 32'(found), 32'h1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("t4_valid", 32'(evt_valid), 32'h1);
        chk("t4_mask",  32'(evt_mask),  32'h04);
        accept_one();

        // 5: all pins rise together
        pin_in = 8'h00;
        evt_ready = 1'b1;
        ticks(12);
        evt_ready = 1'b0;
        pin_in = 8'hFF;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (m_rise != 0) found = 1'b1;
        end
        chk("t5_rise", 32'(rise_out), 32'hFF);
        tick();
        chk("t5_valid", 32'(evt_valid), 32'h1);
        chk("t5_mask",  32'(evt_mask),  32'hFF);

        // 6: async reset mid-debounce with an event pending
        pin_in = 8'hF7;
        ticks(4);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_data",  32'(data_out),  32'h0);
        chk("t6_valid", 32'(evt_valid), 32'h0);
        chk("t6_mask",  32'(evt_mask),  32'h0);
        chk("t6_level", 32'(evt_level), 32'h0);
        chk("t6_ovf",   32'(evt_ovf),   32'h0);
        model_reset();
        tick();
        reset_n = 1'b1;
        ticks(10);

        // Random phase
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 1) == 0) pin_in = 8'($urandom);
                else pin_in = pin_in ^ (8'h01 << $urandom_range(0, 7));
                hold = $urandom_range(1, 8);
            end
            hold--;
            evt_ready = ($urandom_range(0, 3) == 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
